// File: rtl/deserializador_if.sv
// Handshake bundle between the serial-to-parallel front end and its environment.
// master is the deserializer's view; slave is the bit source / word consumer.
interface deserializador_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             write_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             status_out;
  logic             drop_out;

  modport master (
    input  data_in,
    input  write_in,
    input  ack_in,
    output data_out,
    output data_ready,
    output status_out,
    output drop_out
  );

  modport slave (
    output data_in,
    output write_in,
    output ack_in,
    input  data_out,
    input  data_ready,
    input  status_out,
    input  drop_out
  );
endinterface

// File: rtl/deserializador.sv
// Collects serial bits into WIDTH-bit words; word is presented the edge after its last bit.
// While a word awaits ack the block is busy: incoming bits are discarded and flagged on drop_out.
module deserializador #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_100KHz,
  input  logic              reset,
  deserializador_if.master  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word_q;
  logic             drop_q;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == COLLECT) && bus.write_in;
  assign last_bit = (count == CW'(WIDTH - 1));

  // Bit ordering is fixed at elaboration; only one shift direction is built.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_nxt = {shift_q[WIDTH-2:0], bus.data_in};
    end else begin : g_lsb_first
      assign shift_nxt = {bus.data_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (accept && last_bit) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack_in) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // The completed word is taken from shift_nxt so the final bit lands in the same edge.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= (state == HOLD) && bus.write_in;
      if (accept) begin
        if (last_bit) begin
          word_q  <= shift_nxt;
          shift_q <= '0;
          count   <= '0;
        end else begin
          shift_q <= shift_nxt;
          count   <= count + CW'(1);
        end
      end
    end
  end

  assign bus.data_out   = word_q;
  assign bus.data_ready = (state == HOLD);
  assign bus.status_out = (state == HOLD);
  assign bus.drop_out   = drop_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed bench: MSB-first and LSB-first instances share one serial stream;
// expected words go into per-instance queues and are checked when data_ready rises.
module tb_deserializador;

  logic clk;
  logic rst_n;
  logic data_in;
  logic write_in;
  logic ack_in;

  int vectors;
  int miscompares;

  logic [7:0] qm[$];
  logic [7:0] ql[$];
  logic       prev_m;
  logic       prev_l;

  deserializador_if #(.WIDTH(8)) bm ();
  deserializador_if #(.WIDTH(8)) bl ();

  assign bm.data_in  = data_in;
  assign bm.write_in = write_in;
  assign bm.ack_in   = ack_in;
  assign bl.data_in  = data_in;
  assign bl.write_in = write_in;
  assign bl.ack_in   = ack_in;

  deserializador #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_100KHz (clk),
    .reset      (rst_n),
    .bus        (bm)
  );

  deserializador #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_100KHz (clk),
    .reset      (rst_n),
    .bus        (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Scoreboard pop on each rising data_ready
  always @(posedge clk) begin
    #2;
    if (bm.data_ready && !prev_m) begin
      check("q_nonempty_m", 32'(qm.size() != 0), 32'd1);
      if (qm.size() != 0) check("word_m", 32'(bm.data_out), 32'(qm.pop_front()));
    end
    if (bl.data_ready && !prev_l) begin
      check("q_nonempty_l", 32'(ql.size() != 0), 32'd1);
      if (ql.size() != 0) check("word_l", 32'(bl.data_out), 32'(ql.pop_front()));
    end
    prev_m = bm.data_ready;
    prev_l = bl.data_ready;
  end

  task automatic push_word(input logic [7:0] w);
    qm.push_back(w);
    ql.push_back(rev8(w));
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    @(posedge clk);
    #1;
    write_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    push_word(w);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 1) check("early_ready", 32'(bm.data_ready), 32'd0);
    end
    check("ready_after_word", 32'(bm.data_ready), 32'd1);
    check("status_after_word", 32'(bm.status_out), 32'd1);
    check("data_after_word", 32'(bm.data_out), 32'(w));
    check("ready_after_word_l", 32'(bl.data_ready), 32'd1);
  endtask

  task automatic do_ack();
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    check("ready_after_ack", 32'(bm.data_ready), 32'd0);
    check("status_after_ack", 32'(bm.status_out), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_m      = 1'b0;
    prev_l      = 1'b0;
    rst_n       = 1'b0;
    data_in     = 1'b0;
    write_in    = 1'b0;
    ack_in      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(bm.data_out), 32'h00);
    check("rst_ready", 32'(bm.data_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_data", 32'(bm.data_out), 32'h00);
    check("rel_ready", 32'(bm.data_ready), 32'd0);
    check("rel_status", 32'(bm.status_out), 32'd0);
    check("rel_drop", 32'(bm.drop_out), 32'd0);

    // First word, ack, back-to-back second word
    send_word(8'hA5);
    do_ack();
    check("data_kept_after_ack", 32'(bm.data_out), 32'hA5);
    send_word(8'h3C);
    do_ack();

    // Drops while holding
    send_word(8'h5A);
    data_in  = 1'b1;
    write_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("drop_high", 32'(bm.drop_out), 32'd1);
      check("hold_ready", 32'(bm.data_ready), 32'd1);
    end
    write_in = 1'b0;
    @(posedge clk);
    #1;
    check("drop_low", 32'(bm.drop_out), 32'd0);
    check("data_unchanged", 32'(bm.data_out), 32'h5A);
    do_ack();
    send_word(8'h96);
    do_ack();

    // Asynchronous reset in the middle of a partial word
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_data", 32'(bm.data_out), 32'h00);
    check("async_ready", 32'(bm.data_ready), 32'd0);
    check("async_status", 32'(bm.status_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'h81);

    // Ack and write in the same HOLD cycle
    ack_in   = 1'b1;
    write_in = 1'b1;
    data_in  = 1'b1;
    @(posedge clk);
    #1;
    ack_in   = 1'b0;
    write_in = 1'b0;
    check("ackw_ready", 32'(bm.data_ready), 32'd0);
    check("ackw_status", 32'(bm.status_out), 32'd0);
    check("ackw_drop", 32'(bm.drop_out), 32'd1);
    @(posedge clk);
    #1;
    check("ackw_drop_end", 32'(bm.drop_out), 32'd0);

    // Ack in COLLECT in the middle of a word must not disturb the count
    push_word(8'hC3);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    check("collect_ack_ready", 32'(bm.data_ready), 32'd0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("split_ready", 32'(bm.data_ready), 32'd1);
    check("split_data", 32'(bm.data_out), 32'hC3);
    check("split_data_l", 32'(bl.data_out), 32'(rev8(8'hC3)));
    do_ack();

    // LSB-first instance on the A5 pattern
    send_word(8'hA5);
    check("lsb_first_a5", 32'(bl.data_out), 32'hA5);
    do_ack();

    @(posedge clk);
    #3;
    check("queue_m_drained", 32'(qm.size()), 32'd0);
    check("queue_l_drained", 32'(ql.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
